// File: rtl/spi_globals_pkg.sv
// Shared SPI definitions: the chip-select count and the types used by the transfer scheduler.
package spi_globals_pkg;

    localparam int unsigned SPI_NO_OF_SLAVES          = 3;
    localparam int unsigned SPI_SCHED_TIMEOUT_DEFAULT = 4096;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        C2T,
        XFER,
        T2C,
        WAIT
    } spi_sched_state_e;

    typedef struct packed {
        logic [7:0] baud_div;
        logic [7:0] c2t;
        logic [7:0] t2c;
        logic [7:0] wdelay;
    } spi_sched_cfg_s;

    // Delay units to pclk cycles; a zero divider behaves as a divider of one.
    function automatic logic [15:0] spi_units_to_cycles(input logic [7:0] units,
                                                        input logic [7:0] baud_div);
        logic [7:0] w_baud;
        w_baud = (baud_div == 8'd0) ? 8'd1 : baud_div;
        return {8'd0, units} * {8'd0, w_baud};
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin requester pick: combinational search from a registered pointer.
module spi_rr_arbiter #(
    parameter int unsigned NO_OF_REQ = 4
) (
    input  logic                 i_pclk,
    input  logic                 i_areset,
    input  logic [NO_OF_REQ-1:0] i_req,
    input  logic                 i_advance,
    input  logic [(NO_OF_REQ > 1 ? $clog2(NO_OF_REQ) : 1)-1:0] i_last_idx,
    output logic                 o_valid,
    output logic [(NO_OF_REQ > 1 ? $clog2(NO_OF_REQ) : 1)-1:0] o_idx,
    output logic [NO_OF_REQ-1:0] o_onehot
);
    localparam int unsigned IDX_W = (NO_OF_REQ > 1) ? $clog2(NO_OF_REQ) : 1;

    logic [IDX_W-1:0] r_ptr;
    int unsigned      w_j;

    always_comb begin
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_j      = 0;
        // Walk from the far end so the requester closest to the pointer is written last.
        for (int i = NO_OF_REQ - 1; i >= 0; i--) begin
            w_j = (32'(r_ptr) + 32'(i)) % NO_OF_REQ;
            if (i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_j);
            end
        end
        if (o_valid) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_pclk or negedge i_areset) begin
        if (!i_areset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (i_last_idx == IDX_W'(NO_OF_REQ - 1)) ? '0 : i_last_idx + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_xfer_scheduler.sv
// Arbitrates requesters onto one SPI shift engine and sequences CS, start and the CS delays.
module spi_master_xfer_scheduler
    import spi_globals_pkg::*;
#(
    parameter int unsigned NO_OF_REQ    = 4,
    parameter int unsigned NO_OF_SLAVES = SPI_NO_OF_SLAVES,
    parameter int unsigned SLV_W        = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1,
    parameter int unsigned TIMEOUT      = SPI_SCHED_TIMEOUT_DEFAULT
) (
    input  logic                       i_pclk,
    input  logic                       i_areset,
    input  logic [NO_OF_REQ-1:0]       i_req,
    input  logic [NO_OF_REQ*SLV_W-1:0] i_req_slave,
    input  logic [7:0]                 i_cfg_baud_div,
    input  logic [7:0]                 i_cfg_c2t,
    input  logic [7:0]                 i_cfg_t2c,
    input  logic [7:0]                 i_cfg_wdelay,
    output logic [NO_OF_REQ-1:0]       o_gnt,
    output logic [NO_OF_SLAVES-1:0]    o_cs,
    output logic                       o_xfer_start,
    input  logic                       i_xfer_done,
    output logic                       o_busy,
    output logic                       o_timeout_err
);
    localparam int unsigned REQ_W       = (NO_OF_REQ > 1) ? $clog2(NO_OF_REQ) : 1;
    localparam logic [15:0] TIMEOUT_CYC = 16'(TIMEOUT);

    spi_sched_state_e     r_state;
    spi_sched_cfg_s       w_cfg;
    logic [15:0]          r_cnt;
    logic [15:0]          r_t2c_cyc;
    logic [15:0]          r_wait_cyc;
    logic [REQ_W-1:0]     r_gnt_idx;
    logic [REQ_W-1:0]     w_pick_idx;
    logic [NO_OF_REQ-1:0] w_pick_onehot;
    logic                 w_pick_valid;
    logic                 w_cnt_last;
    logic                 w_ptr_adv;
    logic [SLV_W-1:0]     w_pick_slv;

    assign w_cfg = '{baud_div: i_cfg_baud_div, c2t: i_cfg_c2t,
                     t2c: i_cfg_t2c, wdelay: i_cfg_wdelay};
    // A loaded count of 0 or 1 both mean a single cycle in the state.
    assign w_cnt_last = (r_cnt <= 16'd1);
    assign w_ptr_adv  = (r_state == T2C) && w_cnt_last;
    assign w_pick_slv = i_req_slave[32'(w_pick_idx) * SLV_W +: SLV_W];

    function automatic logic [NO_OF_SLAVES-1:0] cs_decode(input logic [SLV_W-1:0] idx);
        logic [NO_OF_SLAVES-1:0] w_v;
        w_v = '1;
        for (int s = 0; s < NO_OF_SLAVES; s++) begin
            if (32'(idx) == 32'(s)) begin
                w_v[s] = 1'b0;
            end
        end
        return w_v;
    endfunction

    spi_rr_arbiter #(
        .NO_OF_REQ (NO_OF_REQ)
    ) u_arb (
        .i_pclk     (i_pclk),
        .i_areset   (i_areset),
        .i_req      (i_req),
        .i_advance  (w_ptr_adv),
        .i_last_idx (r_gnt_idx),
        .o_valid    (w_pick_valid),
        .o_idx      (w_pick_idx),
        .o_onehot   (w_pick_onehot)
    );

    always_ff @(posedge i_pclk or negedge i_areset) begin
        if (!i_areset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_t2c_cyc     <= '0;
            r_wait_cyc    <= '0;
            r_gnt_idx     <= '0;
            o_gnt         <= '0;
            o_cs          <= '1;
            o_xfer_start  <= 1'b0;
            o_busy        <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_xfer_start  <= 1'b0;
            o_timeout_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_state <= ARB;
                        o_busy  <= 1'b1;
                    end
                end
                ARB: begin
                    if (w_pick_valid) begin
                        r_gnt_idx  <= w_pick_idx;
                        o_gnt      <= w_pick_onehot;
                        o_cs       <= cs_decode(w_pick_slv);
                        r_cnt      <= spi_units_to_cycles(w_cfg.c2t, w_cfg.baud_div);
                        r_t2c_cyc  <= spi_units_to_cycles(w_cfg.t2c, w_cfg.baud_div);
                        r_wait_cyc <= spi_units_to_cycles(w_cfg.wdelay, w_cfg.baud_div);
                        r_state    <= C2T;
                    end else begin
                        // Request withdrawn between IDLE and ARB.
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                C2T: begin
                    if (w_cnt_last) begin
                        r_state      <= XFER;
                        o_xfer_start <= 1'b1;
                        r_cnt        <= TIMEOUT_CYC;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                XFER: begin
                    if (i_xfer_done || w_cnt_last) begin
                        o_timeout_err <= !i_xfer_done;
                        r_state       <= T2C;
                        r_cnt         <= r_t2c_cyc;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                T2C: begin
                    if (w_cnt_last) begin
                        o_cs  <= '1;
                        o_gnt <= '0;
                        r_cnt <= r_wait_cyc;
                        if (r_wait_cyc == 16'd0) begin
                            r_state <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                WAIT: begin
                    if (w_cnt_last) begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                    o_cs    <= '1;
                    o_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master_xfer_scheduler.md
# spi_master_xfer_scheduler

Shares one SPI master shift engine among several requesters and sequences every character transfer around it. Round-robin arbitration picks a requester, then the block drives the selected chip-select low and times the CS-to-SCLK (C2T) delay. It then issues a start pulse to the shift engine, waits for its done pulse, times the SCLK-to-CS (T2C) delay and the inter-transfer wait delay, and releases CS. It sits between the HDL-side request sources and the SCLK/MOSI/MISO shift datapath.

## Interface
- NO_OF_REQ, 4, number of requesters (≥1)
- NO_OF_SLAVES, from spi_globals_pkg, chip-select width
- SLV_W, $clog2(NO_OF_SLAVES) (min 1), slave-index width
- TIMEOUT, 4096, pclk cycles allowed between xfer_start and xfer_done

- pclk  in  1  system clock, all logic on posedge
- areset  in  1  asynchronous, active-low reset
- req  in  NO_OF_REQ  per-requester transfer request, level
- req_slave  in  NO_OF_REQ*SLV_W  slave index for requester i at [i*SLV_W +: SLV_W]
- cfg_baud_div  in  8  pclk cycles per delay unit; 0 treated as 1
- cfg_c2t  in  8  C2T delay in units
- cfg_t2c  in  8  T2C delay in units
- cfg_wdelay  in  8  CS-high wait after T2C, in units
- gnt  out  NO_OF_REQ  one-hot grant, held for whole transfer
- cs  out  NO_OF_SLAVES  active-low chip selects
- xfer_start  out  1  one-cycle pulse to shift engine
- xfer_done  in  1  one-cycle pulse from shift engine
- busy  out  1  high whenever state ≠ IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry

## Operation
- Reset values: gnt=0, cs=all 1, xfer_start=0, busy=0, timeout_err=0, state=IDLE, rr pointer=0.
- States:
  - IDLE: if any req, go to ARB.
  - ARB: take the first requester at or after the rr pointer with req=1. Latch gnt, the slave index, cfg_c2t×baud, cfg_t2c×baud and cfg_wdelay×baud as 16-bit products. Go to C2T.
  - C2T: cs[idx]=0. Hold for max(1, c2t×baud) cycles, then go to XFER.
  - XFER: xfer_start=1 in the first cycle only. Wait for xfer_done, then go to T2C.
  - T2C: cs[idx] stays 0 for max(1, t2c×baud) cycles, then go to WAIT.
  - WAIT: all cs=1 and gnt=0. Hold for wdelay×baud cycles (0 allowed), then go to IDLE.
  - The rr pointer moves to the granted index+1 (mod NO_OF_REQ) on leaving T2C.
- Config inputs are sampled only in ARB. Changes mid-transfer do not affect the current transfer.
- Dropping req after grant does not abort; the transfer completes.
- req_slave ≥ NO_OF_SLAVES: no cs asserted, sequence still runs. This is a bench-visible error case and must not hang.
- Watchdog: a counter starts at xfer_start. If it reaches TIMEOUT cycles with no xfer_done, timeout_err pulses and the state goes to T2C.
- xfer_done outside XFER is ignored.
- Exactly one cs bit is low at any time, or none.
- areset asserted mid-operation: all outputs return to reset values immediately (asynchronously). The rr pointer is cleared.

## Timing
- Earliest req seen in IDLE at edge N: ARB at N+1, cs low registered at N+2.
- With c2t×baud=D, xfer_start is high in cycle N+2+max(1,D).
- Pulse→state latency is one cycle. cs rises exactly max(1,T) cycles after the cycle in which xfer_done is sampled.
- Back-to-back transfers: the minimum CS-high time is wdelay×baud cycles + 2 (IDLE + ARB).
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- spi_globals_pkg gets:
  - a typedef enum spi_sched_state_e {IDLE, ARB, C2T, XFER, T2C, WAIT}
  - a typedef struct spi_sched_cfg_s {baud_div, c2t, t2c, wdelay}
  - a constant SPI_SCHED_TIMEOUT_DEFAULT = 4096
- The natural sub-module is spi_rr_arbiter: a combinational masked priority pick plus a registered pointer, parameterised by NO_OF_REQ.
- The delay counter is one shared 16-bit down-counter, reloaded on each state entry.

## Test plan
- Reset, then req=4'b0001, slave 2, baud=2, c2t=3, t2c=1, wdelay=0 → cs=~(1<<2) for 6 cycles before xfer_start. After xfer_done, cs stays low 2 cycles, then cs=all 1.
- req=4'b1111 held, done returned each transfer → grants go 0,1,2,3,0 in order, each gnt one-hot.
- c2t=0, t2c=0, baud=0 → xfer_start exactly 1 cycle after cs falls, and cs rises 1 cycle after done.
- No xfer_done, TIMEOUT=16 → timeout_err pulse 16 cycles after xfer_start, then cs rises after the T2C count.
- areset dropped during XFER → cs=all 1, gnt=0, busy=0 in the same cycle. After release, req=4'b0010 is granted as the first grant (pointer cleared).
- Change cfg_c2t during C2T, and pulse a stray xfer_done during WAIT → the timing of the current transfer is unchanged, and the stray done has no effect.
